// File: rtl/spart_driver_if.sv
// Bus and receiver/transmitter handshake signals between spart_driver and the SPART core.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] wr_data;
  logic       clr_rda;
  logic       rda;
  logic       tbr;
  logic [7:0] rx_data;

  modport master (
    output iocs, iorw, ioaddr, wr_data, clr_rda,
    input  rda, tbr, rx_data
  );

  modport slave (
    input  iocs, iorw, ioaddr, wr_data, clr_rda,
    output rda, tbr, rx_data
  );
endinterface

// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor, then echoes received bytes back
// through a 4-entry FIFO, reprogramming whenever br_cfg changes.
module spart_driver (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            br_cfg,
  spart_driver_if.master        bus,
  output logic [2:0]            fifo_count,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    INIT_LO, INIT_HI, IDLE, RD_ACK, RD_CAP, WR_TX, TX_HOLD
  } state_t;

  state_t      state, next_state;
  logic [1:0]  cfg_q;
  logic [1:0]  rd_ptr, wr_ptr;
  logic [7:0]  fifo_mem [4];
  logic        fifo_full;

  // Divisor for a 100 MHz clock with 16x oversampling.
  function automatic logic [7:0] divisor_byte(input logic [1:0] sel, input logic hi);
    logic [15:0] d;
    case (sel)
      2'b00:   d = 16'h0515;
      2'b01:   d = 16'h028A;
      2'b10:   d = 16'h0145;
      default: d = 16'h00A2;
    endcase
    return hi ? d[15:8] : d[7:0];
  endfunction

  assign fifo_full = (fifo_count == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_LO;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT_LO: next_state = INIT_HI;
      INIT_HI: next_state = IDLE;
      IDLE: begin
        if (br_cfg != cfg_q)                  next_state = INIT_LO;
        else if (bus.rda)                     next_state = RD_ACK;
        else if (fifo_count != '0 && bus.tbr) next_state = WR_TX;
      end
      RD_ACK:  next_state = RD_CAP;
      RD_CAP:  next_state = IDLE;
      WR_TX:   next_state = TX_HOLD;
      TX_HOLD: next_state = IDLE;
      default: next_state = INIT_LO;
    endcase
  end

  // Reset forces the bus quiet combinationally, so the INIT_LO that reset
  // parks in only becomes visible once rst is released.
  always_comb begin
    bus.iocs    = 1'b0;
    bus.iorw    = 1'b1;
    bus.ioaddr  = 2'b01;
    bus.wr_data = '0;
    bus.clr_rda = 1'b0;
    if (!rst) begin
      case (state)
        INIT_LO: begin
          bus.iocs    = 1'b1;
          bus.iorw    = 1'b0;
          bus.ioaddr  = 2'b10;
          bus.wr_data = divisor_byte(br_cfg, 1'b0);
        end
        INIT_HI: begin
          bus.iocs    = 1'b1;
          bus.iorw    = 1'b0;
          bus.ioaddr  = 2'b11;
          bus.wr_data = divisor_byte(cfg_q, 1'b1);
        end
        RD_ACK: begin
          bus.iocs    = 1'b1;
          bus.iorw    = 1'b1;
          bus.ioaddr  = 2'b00;
          bus.clr_rda = 1'b1;
        end
        WR_TX: begin
          bus.iocs    = 1'b1;
          bus.iorw    = 1'b0;
          bus.ioaddr  = 2'b00;
          bus.wr_data = fifo_mem[rd_ptr];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (state == INIT_LO) cfg_q <= br_cfg;
      if (state == RD_CAP) begin
        if (fifo_full) begin
          overrun <= 1'b1;
        end else begin
          wr_ptr     <= wr_ptr + 2'd1;
          fifo_count <= fifo_count + 3'd1;
        end
      end
      if (state == WR_TX) begin
        rd_ptr     <= rd_ptr + 2'd1;
        fifo_count <= fifo_count - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == RD_CAP && !fifo_full) fifo_mem[wr_ptr] <= bus.rx_data;
  end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: transaction-script model checked every cycle plus
// directed scenarios with literal expectations.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic [2:0] fifo_count;
  logic       overrun;

  spart_driver_if bus ();

  spart_driver dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .bus        (bus.master),
    .fifo_count (fifo_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Receiver emulation: bytes waiting in rx_q; the acked byte appears on rx_data next cycle.
  logic [7:0] rx_q[$];
  logic       ack_seen = 1'b0;

  always @(negedge clk) ack_seen = bus.clr_rda;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack_seen && rx_q.size() != 0) bus.rx_data = rx_q.pop_front();
      bus.rda = (rx_q.size() != 0);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    bus.rda = 1'b1;
  endtask

  // Model: each IDLE decision schedules a short script of bus cycles.
  typedef enum {K_IDLE, K_LO, K_HI, K_ACK, K_CAP, K_TX, K_HOLD} kind_t;
  kind_t      sched[$];
  logic [7:0] mq[$];
  logic [1:0] mcfg;
  bit         movr;

  function automatic logic [15:0] div_of(input logic [1:0] s);
    case (s)
      2'b00:   return 16'h0515;
      2'b01:   return 16'h028A;
      2'b10:   return 16'h0145;
      default: return 16'h00A2;
    endcase
  endfunction

  always @(negedge clk) begin
    kind_t       k;
    logic        e_iocs, e_iorw, e_clr;
    logic [1:0]  e_addr;
    logic [7:0]  e_wd;
    logic [15:0] d;
    k = K_IDLE;
    if (!rst && sched.size() != 0) k = sched.pop_front();
    e_iocs = 1'b0; e_iorw = 1'b1; e_addr = 2'b01; e_wd = 8'h00; e_clr = 1'b0;
    if (!rst) begin
      case (k)
        K_LO:  begin d = div_of(br_cfg); e_iocs = 1; e_iorw = 0; e_addr = 2'b10; e_wd = d[7:0]; end
        K_HI:  begin d = div_of(mcfg);   e_iocs = 1; e_iorw = 0; e_addr = 2'b11; e_wd = d[15:8]; end
        K_ACK: begin e_iocs = 1; e_iorw = 1; e_addr = 2'b00; e_clr = 1; end
        K_TX:  begin e_iocs = 1; e_iorw = 0; e_addr = 2'b00; e_wd = (mq.size() != 0) ? mq[0] : 8'h00; end
        default: ;
      endcase
    end
    check("iocs",    16'(bus.iocs),    16'(e_iocs));
    check("iorw",    16'(bus.iorw),    16'(e_iorw));
    check("ioaddr",  16'(bus.ioaddr),  16'(e_addr));
    check("wr_data", 16'(bus.wr_data), 16'(e_wd));
    check("clr_rda", 16'(bus.clr_rda), 16'(e_clr));
    if (!rst) begin
      check("fifo_count", 16'(fifo_count), 16'(mq.size()));
      check("overrun",    16'(overrun),    16'(movr));
    end
    if (rst) begin
      mq.delete();
      movr = 0;
      mcfg = 2'b00;
      sched.delete();
      sched.push_back(K_LO);
      sched.push_back(K_HI);
    end else begin
      case (k)
        K_LO:  mcfg = br_cfg;
        K_CAP: if (mq.size() < 4) mq.push_back(bus.rx_data); else movr = 1;
        K_TX:  if (mq.size() != 0) void'(mq.pop_front());
        K_IDLE: begin
          if (br_cfg != mcfg) begin sched.push_back(K_LO); sched.push_back(K_HI); end
          else if (bus.rda) begin sched.push_back(K_ACK); sched.push_back(K_CAP); end
          else if (mq.size() != 0 && bus.tbr) begin sched.push_back(K_TX); sched.push_back(K_HOLD); end
        end
        default: ;
      endcase
    end
  end

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input string name, input logic [7:0] exp);
    bit found = 0;
    for (int unsigned i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) found = 1;
    end
    if (found) check(name, 16'(bus.wr_data), 16'(exp));
    else       check({name, "_timeout"}, 16'h0, 16'h1);
  endtask

  task automatic wait_access(output bit found);
    found = 0;
    for (int unsigned i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.iocs) found = 1;
    end
    if (!found) check("access_timeout", 16'h0, 16'h1);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; br_cfg = 2'b01; bus.rda = 1'b0; bus.tbr = 1'b0; bus.rx_data = 8'h00;
    cycles(3);
    rst = 1'b0;
    // Divisor programming right after reset
    @(negedge clk);
    check("init_lo_addr", 16'(bus.ioaddr), 16'h2);
    check("init_lo_data", 16'(bus.wr_data), 16'h8A);
    check("init_lo_iocs", 16'(bus.iocs), 16'h1);
    @(negedge clk);
    check("init_hi_addr", 16'(bus.ioaddr), 16'h3);
    check("init_hi_data", 16'(bus.wr_data), 16'h02);
    @(negedge clk);
    check("idle_iocs", 16'(bus.iocs), 16'h0);

    // Single echo
    @(posedge clk); #1;
    bus.tbr = 1'b1;
    send(8'h41);
    wait_write("echo_41", 8'h41);
    @(negedge clk);
    check("echo_empty", 16'(fifo_count), 16'h0);

    // Overflow with transmitter blocked, then ordered drain
    @(posedge clk); #1;
    bus.tbr = 1'b0;
    for (int unsigned i = 0; i < 5; i++) send(8'h10 + 8'(i));
    cycles(25);
    check("ovf_count", 16'(fifo_count), 16'h4);
    check("ovf_flag",  16'(overrun), 16'h1);
    bus.tbr = 1'b1;
    for (int unsigned i = 0; i < 4; i++) wait_write("drain", 8'h10 + 8'(i));
    cycles(4);
    check("drain_empty", 16'(fifo_count), 16'h0);

    // Simultaneous read request and write opportunity: read wins
    bus.tbr = 1'b0;
    send(8'h21); send(8'h22);
    cycles(10);
    send(8'h23);
    bus.tbr = 1'b1;
    wait_access(ok);
    if (ok) check("read_first", 16'(bus.clr_rda), 16'h1);
    wait_write("prio_21", 8'h21);
    check("prio_count", 16'(fifo_count), 16'h3);
    wait_write("prio_22", 8'h22);
    wait_write("prio_23", 8'h23);
    cycles(3);

    // Baud change during a read: read finishes, then reprogram
    bus.tbr = 1'b0;
    send(8'h31);
    ok = 0;
    for (int unsigned i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.clr_rda) ok = 1;
    end
    if (!ok) check("ack_timeout", 16'h0, 16'h1);
    br_cfg = 2'b11;
    wait_access(ok);
    if (ok) begin
      check("recfg_lo_addr", 16'(bus.ioaddr), 16'h2);
      check("recfg_lo_data", 16'(bus.wr_data), 16'hA2);
      @(negedge clk);
      check("recfg_hi_addr", 16'(bus.ioaddr), 16'h3);
      check("recfg_hi_data", 16'(bus.wr_data), 16'h00);
      check("recfg_count",   16'(fifo_count), 16'h1);
    end

    // Reset during WR_TX with three bytes queued
    @(posedge clk); #1;
    send(8'h51); send(8'h52);
    cycles(12);
    check("pre_rst_count", 16'(fifo_count), 16'h3);
    bus.tbr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_iocs", 16'(bus.iocs), 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_count",   16'(fifo_count), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    check("rst_ioaddr",  16'(bus.ioaddr), 16'h1);
    check("rst_iorw",    16'(bus.iorw), 16'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.tbr = 1'b0;
    @(negedge clk);
    check("post_rst_lo", 16'(bus.wr_data), 16'hA2);
    cycles(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
